// File: rtl/mem_sync_pkg.sv
// Shared definitions for the CPU/bus memory synchroniser: FSM states,
// channel roles and the default WAIT-cycle limit.
package mem_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  localparam int CH_INSTR = 0;
  localparam int CH_DATA  = 1;

  localparam int DEFAULT_TIMEOUT_CYC = 255;

endpackage

// File: rtl/mem_sync_chan.sv
// One channel of the synchroniser: its pending bit and the read-data latch
// that holds the bus data captured when the channel completed.
module mem_sync_chan #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start,
  input  logic              in_wait,
  input  logic              active,
  input  logic              ready,
  input  logic [DATA_W-1:0] rdata,
  output logic              pend,
  output logic [DATA_W-1:0] data
);

  // Channels that never complete keep a zero latch, so a timed-out read returns 0.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pend <= 1'b0;
      data <= '0;
    end else if (start) begin
      pend <= active & ~ready;
      data <= (active && ready) ? rdata : '0;
    end else if (in_wait && pend && ready) begin
      pend <= 1'b0;
      data <= rdata;
    end
  end

endmodule

// File: rtl/mem_sync_ctrl.sv
// Stalls the CPU until every active bus channel has completed, with zero-wait
// pass-through when all active channels are already ready, and a WAIT timeout.
module mem_sync_ctrl
  import mem_sync_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_CH-1:0]        cpu_rd_i,
  input  logic [NUM_CH-1:0]        cpu_wr_i,
  input  logic [NUM_CH*ADDR_W-1:0] cpu_addr_i,
  input  logic [NUM_CH*DATA_W-1:0] cpu_wdata_i,
  output logic [NUM_CH*DATA_W-1:0] cpu_rdata_o,
  output logic                     mem_ready_o,
  output logic                     mem_err_o,
  output logic [NUM_CH-1:0]        bus_rd_o,
  output logic [NUM_CH-1:0]        bus_wr_o,
  output logic [NUM_CH*ADDR_W-1:0] bus_addr_o,
  output logic [NUM_CH*DATA_W-1:0] bus_wdata_o,
  input  logic [NUM_CH*DATA_W-1:0] bus_rdata_i,
  input  logic [NUM_CH-1:0]        bus_ready_i
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

  state_e                   state_r;
  logic [CNT_W-1:0]         cnt_r;
  logic                     err_r;
  logic [NUM_CH-1:0]        active;
  logic [NUM_CH-1:0]        pend;
  logic [NUM_CH-1:0]        still_pend;
  logic [NUM_CH*DATA_W-1:0] latched;
  logic                     all_ready;
  logic                     start_wait;
  logic                     in_wait;
  logic                     timeout_hit;

  assign active      = cpu_rd_i | cpu_wr_i;
  assign all_ready   = ((active & ~bus_ready_i) == '0);
  assign in_wait     = (state_r == ST_WAIT);
  assign start_wait  = (state_r == ST_IDLE) && (active != '0) && !all_ready;
  assign still_pend  = pend & ~bus_ready_i;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_r == CNT_LIMIT);

  assign bus_addr_o  = cpu_addr_i;
  assign bus_wdata_o = cpu_wdata_i;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    mem_sync_chan #(.DATA_W(DATA_W)) u_chan (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start   (start_wait),
      .in_wait (in_wait),
      .active  (active[g]),
      .ready   (bus_ready_i[g]),
      .rdata   (bus_rdata_i[g*DATA_W +: DATA_W]),
      .pend    (pend[g]),
      .data    (latched[g*DATA_W +: DATA_W])
    );
  end

  // The counter equals the number of WAIT cycles already spent; a completion
  // in the same cycle the limit is reached takes priority over the timeout.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_wait) begin
            state_r <= ST_WAIT;
            cnt_r   <= '0;
            err_r   <= 1'b0;
          end
        end
        ST_WAIT: begin
          cnt_r <= cnt_r + 1'b1;
          if (still_pend == '0) begin
            state_r <= ST_ACK;
          end else if (timeout_hit) begin
            state_r <= ST_ACK;
            err_r   <= 1'b1;
          end
        end
        ST_ACK:  state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus_rd_o    = '0;
    bus_wr_o    = '0;
    mem_ready_o = 1'b0;
    mem_err_o   = 1'b0;
    cpu_rdata_o = '0;
    if (rst_i) begin
      case (state_r)
        ST_IDLE: begin
          bus_rd_o    = cpu_rd_i;
          bus_wr_o    = cpu_wr_i;
          cpu_rdata_o = bus_rdata_i;
          mem_ready_o = (active != '0) && all_ready;
        end
        ST_WAIT: begin
          bus_rd_o    = cpu_rd_i & pend;
          bus_wr_o    = cpu_wr_i & pend;
          cpu_rdata_o = latched;
        end
        ST_ACK: begin
          mem_ready_o = 1'b1;
          mem_err_o   = err_r;
          cpu_rdata_o = latched;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sync_ctrl.sv
// Randomised transaction bench for mem_sync_ctrl: each transaction is described
// by per-channel ready cycles, from which the expected handshake is derived.
module tb_mem_sync_ctrl;
  import mem_sync_pkg::*;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int TO     = 4;

  logic                     clk_i = 1'b0;
  logic                     rst_i = 1'b0;
  logic [NUM_CH-1:0]        cpu_rd_i = '0;
  logic [NUM_CH-1:0]        cpu_wr_i = '0;
  logic [NUM_CH*ADDR_W-1:0] cpu_addr_i = '0;
  logic [NUM_CH*DATA_W-1:0] cpu_wdata_i = '0;
  logic [NUM_CH*DATA_W-1:0] cpu_rdata_o;
  logic                     mem_ready_o;
  logic                     mem_err_o;
  logic [NUM_CH-1:0]        bus_rd_o;
  logic [NUM_CH-1:0]        bus_wr_o;
  logic [NUM_CH*ADDR_W-1:0] bus_addr_o;
  logic [NUM_CH*DATA_W-1:0] bus_wdata_o;
  logic [NUM_CH*DATA_W-1:0] bus_rdata_i = '0;
  logic [NUM_CH-1:0]        bus_ready_i = '0;

  always #5 clk_i = ~clk_i;

  mem_sync_ctrl #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_rd_i    (cpu_rd_i),
    .cpu_wr_i    (cpu_wr_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .mem_ready_o (mem_ready_o),
    .mem_err_o   (mem_err_o),
    .bus_rd_o    (bus_rd_o),
    .bus_wr_o    (bus_wr_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_rdata_i (bus_rdata_i),
    .bus_ready_i (bus_ready_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit                       exp_valid = 0;
  bit                       exp_rdata_valid = 0;
  logic [NUM_CH-1:0]        exp_rd = '0;
  logic [NUM_CH-1:0]        exp_wr = '0;
  logic                     exp_ready = 1'b0;
  logic                     exp_err = 1'b0;
  logic [NUM_CH*DATA_W-1:0] exp_rdata = '0;

  int                       obs_ack;
  logic                     obs_err;
  logic [NUM_CH*DATA_W-1:0] obs_rdata;
  logic [NUM_CH-1:0]        obs_wr_ack;
  logic [NUM_CH-1:0]        obs_rd_mid;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk_i) begin
    if (exp_valid) begin
      checkOutput("bus_rd", 64'(bus_rd_o), 64'(exp_rd));
      checkOutput("bus_wr", 64'(bus_wr_o), 64'(exp_wr));
      checkOutput("mem_ready", 64'(mem_ready_o), 64'(exp_ready));
      checkOutput("mem_err", 64'(mem_err_o), 64'(exp_err));
      checkOutput("bus_addr", bus_addr_o, cpu_addr_i);
      checkOutput("bus_wdata", bus_wdata_o, cpu_wdata_i);
      if (exp_rdata_valid) checkOutput("cpu_rdata", cpu_rdata_o, exp_rdata);
    end
  end

  // d0/d1: cycle (0 = request cycle) at which each channel raises ready.
  // The handshake outcome follows from the latest active ready cycle alone.
  task automatic applyStimulus(input logic [1:0] rd, input logic [1:0] wr,
                               input int d0, input int d1, input bit fixed,
                               input logic [31:0] fx0, input logic [31:0] fx1);
    int d[2];
    int last, ack;
    bit zero_wait, err;
    logic [1:0] act;
    logic [31:0] cap [2];
    logic [31:0] val;
    d[0] = d0; d[1] = d1;
    act = rd | wr;
    zero_wait = 1; last = 0;
    for (int c = 0; c < 2; c++) begin
      cap[c] = '0;
      if (act[c]) begin
        if (d[c] != 0) zero_wait = 0;
        if (d[c] > last) last = d[c];
      end
    end
    if (zero_wait) begin ack = 0; err = 0; end
    else if (last <= TO + 1) begin ack = last + 1; err = 0; end
    else begin ack = TO + 2; err = 1; end

    obs_ack = -1; obs_err = 1'bx; obs_rdata = 'x; obs_wr_ack = 'x; obs_rd_mid = '0;
    for (int k = 0; k <= ack; k++) begin
      @(posedge clk_i); #1;
      if (k == 0) begin
        cpu_addr_i  = {$urandom, $urandom};
        cpu_wdata_i = {$urandom, $urandom};
      end
      cpu_rd_i = rd;
      cpu_wr_i = wr;
      for (int c = 0; c < 2; c++) begin
        val = (fixed && k == d[c]) ? ((c == 0) ? fx0 : fx1) : $urandom;
        bus_rdata_i[c*DATA_W +: DATA_W] = val;
        if (act[c]) bus_ready_i[c] = (k == d[c]) ? 1'b1 : ((k > d[c]) ? 1'($urandom_range(0, 1)) : 1'b0);
        else        bus_ready_i[c] = 1'($urandom_range(0, 1));
        if (act[c] && k == d[c] && d[c] < ack) cap[c] = val;
      end
      if (k == ack && ack > 0) begin
        exp_rd = '0; exp_wr = '0;
      end else begin
        exp_rd = rd & {(d[1] >= k), (d[0] >= k)};
        exp_wr = wr & {(d[1] >= k), (d[0] >= k)};
      end
      exp_ready = (k == ack);
      exp_err   = (k == ack) && err;
      exp_rdata_valid = (k == 0) || (k == ack);
      exp_rdata = (k == 0) ? bus_rdata_i : {cap[1], cap[0]};
      exp_valid = 1;
      @(negedge clk_i);
      if (mem_ready_o === 1'b1 && obs_ack < 0) begin
        obs_ack = k; obs_err = mem_err_o; obs_rdata = cpu_rdata_o; obs_wr_ack = bus_wr_o;
      end
      if (k >= 1 && k <= 3) obs_rd_mid = obs_rd_mid | bus_rd_o;
    end
    // One idle cycle: no request means no ready and pure pass-through.
    @(posedge clk_i); #1;
    cpu_rd_i = '0; cpu_wr_i = '0;
    bus_ready_i = 2'($urandom_range(0, 3));
    bus_rdata_i = {$urandom, $urandom};
    exp_rd = '0; exp_wr = '0; exp_ready = 0; exp_err = 0;
    exp_rdata_valid = 1; exp_rdata = bus_rdata_i;
  endtask

  initial begin
    logic [1:0] rd, wr;
    int r;
    // Reset state: outputs forced low although requests and data are present.
    cpu_rd_i = 2'b11; bus_ready_i = 2'b11;
    bus_rdata_i = {32'h11112222, 32'h33334444};
    cpu_addr_i = {32'hA0A0A0A0, 32'h0B0B0B0B};
    #12;
    checkOutput("rst_bus_rd", 64'(bus_rd_o), 64'h0);
    checkOutput("rst_mem_ready", 64'(mem_ready_o), 64'h0);
    checkOutput("rst_mem_err", 64'(mem_err_o), 64'h0);
    checkOutput("rst_cpu_rdata", cpu_rdata_o, 64'h0);
    checkOutput("rst_addr_pass", bus_addr_o, 64'hA0A0A0A00B0B0B0B);
    @(posedge clk_i); #1;
    rst_i = 1; cpu_rd_i = '0; bus_ready_i = '0;

    // ch0 read + ch1 write, both ready immediately.
    applyStimulus(2'b01, 2'b10, 0, 0, 1, 32'h12345678, 32'h0);
    checkOutput("zw_ack_cycle", 64'(obs_ack), 64'd0);
    checkOutput("zw_rdata_ch0", 64'(obs_rdata[CH_INSTR*DATA_W +: DATA_W]), 64'h12345678);

    // Both reads, ch1 ready at 0, ch0 at 3.
    applyStimulus(2'b11, 2'b00, 3, 0, 1, 32'hDEADBEEF, 32'hCAFE0001);
    checkOutput("two_ack_cycle", 64'(obs_ack), 64'd4);
    checkOutput("two_rdata", obs_rdata, 64'hCAFE0001DEADBEEF);
    checkOutput("two_rd1_mid", 64'(obs_rd_mid[CH_DATA]), 64'h0);
    checkOutput("two_err", 64'(obs_err), 64'h0);

    // Only ch0 active.
    applyStimulus(2'b01, 2'b00, 0, 9, 0, 32'h0, 32'h0);
    checkOutput("solo_ack_cycle", 64'(obs_ack), 64'd0);

    // ch1 never ready: timeout.
    applyStimulus(2'b01, 2'b10, 1, 40, 1, 32'h55AA55AA, 32'h0);
    checkOutput("to_ack_cycle", 64'(obs_ack), 64'd6);
    checkOutput("to_err", 64'(obs_err), 64'h1);
    checkOutput("to_rdata", obs_rdata, 64'h0000000055AA55AA);
    checkOutput("to_wr1_ack", 64'(obs_wr_ack[CH_DATA]), 64'h0);

    // ch1 ready in the very cycle the limit is reached.
    applyStimulus(2'b01, 2'b10, 0, TO + 1, 1, 32'h01020304, 32'h0);
    checkOutput("race_ack_cycle", 64'(obs_ack), 64'd6);
    checkOutput("race_err", 64'(obs_err), 64'h0);

    // Reset pulse in the middle of WAIT.
    @(posedge clk_i); #1;
    exp_valid = 0;
    cpu_rd_i = 2'b11; cpu_wr_i = '0; bus_ready_i = '0;
    bus_rdata_i = {32'h77778888, 32'h9999AAAA};
    @(negedge clk_i);
    checkOutput("rstw_rd_c0", 64'(bus_rd_o), 64'h3);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checkOutput("rstw_rd_wait", 64'(bus_rd_o), 64'h3);
    checkOutput("rstw_rdy_wait", 64'(mem_ready_o), 64'h0);
    @(posedge clk_i); #1;
    rst_i = 0; bus_ready_i = 2'b11;
    #1;
    checkOutput("rstw_bus_rd", 64'(bus_rd_o), 64'h0);
    checkOutput("rstw_mem_ready", 64'(mem_ready_o), 64'h0);
    checkOutput("rstw_cpu_rdata", cpu_rdata_o, 64'h0);
    @(posedge clk_i); #1;
    cpu_rd_i = '0; bus_ready_i = '0; rst_i = 1;
    @(negedge clk_i);
    checkOutput("rstw_no_ack", 64'(mem_ready_o), 64'h0);
    applyStimulus(2'b01, 2'b10, 2, 1, 1, 32'h0BADF00D, 32'h0);
    checkOutput("rstw_next_ack", 64'(obs_ack), 64'd3);
    checkOutput("rstw_next_rdata", obs_rdata, 64'h000000000BADF00D);

    // Randomised transactions.
    for (int t = 0; t < 80; t++) begin
      rd = '0; wr = '0;
      for (int c = 0; c < 2; c++) begin
        r = $urandom_range(0, 2);
        if (r == 1) rd[c] = 1'b1;
        if (r == 2) wr[c] = 1'b1;
      end
      if ((rd | wr) == '0) rd[0] = 1'b1;
      applyStimulus(rd, wr,
                    ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 8)),
                    ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 8)),
                    0, 32'h0, 32'h0);
    end
    @(negedge clk_i);
    exp_valid = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
